proc_mem_responder: RTL and testbench



---
 rtl/proc_mem_responder_pkg.sv | 11 +
 rtl/proc_mem_responder_pipe.sv | 22 ++
 rtl/proc_mem_responder.sv | 71 +++++++
 tb/tb_proc_mem_responder.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/proc_mem_responder_pkg.sv
// proc_mem_responder_pkg: shared request encodings, default MMIO address and response bundle.
package proc_mem_responder_pkg;
   localparam logic MEM_REQ_READ = 1'b0;
   localparam logic MEM_REQ_WRITE = 1'b1;
   localparam logic [31:0] MMIO_ADDR_DEFAULT = 32'h0001_0000;
   localparam int RESP_W = 1 + 32;
   typedef struct packed {
      logic val;
      logic [31:0] data;
   } resp_t;
endpackage

// File: rtl/proc_mem_responder_pipe.sv
// mem_resp_pipe: LATENCY-deep delay line of {val, data}; stage 0 captures at the request edge.
module mem_resp_pipe
   import proc_mem_responder_pkg::*;
#(
   parameter int LATENCY = 1
) (
   input  logic  clk,
   input  logic  rst,
   input  resp_t d,
   output resp_t q
);
   resp_t stage [LATENCY];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
      end
   end
   assign q = stage[LATENCY-1];
endmodule

// File: rtl/proc_mem_responder.sv
// proc_mem_responder: imem/dmem responder with fixed-latency responses and one MMIO word.
// Optional MEM_ALIGN_CHECK_EN adds a sticky misalign_err output.
module proc_mem_responder
   import proc_mem_responder_pkg::*;
#(
   parameter int          WORDS     = 256,
   parameter int          LATENCY   = 1,
   parameter logic [31:0] MMIO_ADDR = MMIO_ADDR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        imemreq_val,
   input  logic [31:0] imemreq_addr,
   output logic        imemresp_val,
   output logic [31:0] imemresp_data,
   input  logic        dmemreq_val,
   input  logic        dmemreq_type,
   input  logic [31:0] dmemreq_addr,
   input  logic [31:0] dmemreq_wdata,
   output logic        dmemresp_val,
   output logic [31:0] dmemresp_data,
`ifdef MEM_ALIGN_CHECK_EN
   output logic        misalign_err,
`endif
   input  logic [31:0] in_data,
   output logic        out_val,
   output logic [31:0] out_data
);
   localparam int AW = $clog2(WORDS);
   logic [31:0] mem [WORDS];
   logic [AW-1:0] iidx, didx;
   logic i_mmio, d_mmio, d_wr;
   resp_t ireq, dreq, iresp, dresp;
   assign iidx   = imemreq_addr[2 +: AW];
   assign didx   = dmemreq_addr[2 +: AW];
   assign i_mmio = imemreq_addr == MMIO_ADDR;
   assign d_mmio = dmemreq_addr == MMIO_ADDR;
   assign d_wr   = dmemreq_val && dmemreq_type == MEM_REQ_WRITE;
   // Reads see pre-edge contents, so a same-cycle imem read returns old data.
   always_comb begin
      ireq.val  = imemreq_val;
      ireq.data = i_mmio ? in_data : mem[iidx];
      dreq.val  = dmemreq_val;
      dreq.data = d_wr ? 32'h0 : d_mmio ? in_data : mem[didx];
   end
   always_ff @(posedge clk) begin
      if (d_wr && !d_mmio) mem[didx] <= dmemreq_wdata;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_val  <= 1'b0;
         out_data <= '0;
      end else begin
         out_val <= d_wr && d_mmio;
         if (d_wr && d_mmio) out_data <= dmemreq_wdata;
      end
   end
`ifdef MEM_ALIGN_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) misalign_err <= 1'b0;
      else if ((imemreq_val && imemreq_addr[1:0] != 2'b00) ||
               (dmemreq_val && dmemreq_addr[1:0] != 2'b00)) misalign_err <= 1'b1;
   end
`endif
   mem_resp_pipe #(.LATENCY(LATENCY)) u_ipipe (.clk(clk), .rst(rst), .d(ireq), .q(iresp));
   mem_resp_pipe #(.LATENCY(LATENCY)) u_dpipe (.clk(clk), .rst(rst), .d(dreq), .q(dresp));
   assign imemresp_val  = iresp.val;
   assign imemresp_data = iresp.data;
   assign dmemresp_val  = dresp.val;
   assign dmemresp_data = dresp.data;
endmodule

// File: tb/tb_proc_mem_responder.sv
// tb_proc_mem_responder: directed stimulus with a queue scoreboard per response channel.
module tb_proc_mem_responder;
   localparam int LAT = 2;
   localparam logic [31:0] MMIO = 32'h0001_0000;
   logic        clk = 1'b0, rst = 1'b0;
   logic        imemreq_val = 1'b0, dmemreq_val = 1'b0, dmemreq_type = 1'b0;
   logic [31:0] imemreq_addr = '0, dmemreq_addr = '0, dmemreq_wdata = '0, in_data = '0;
   logic        imemresp_val, dmemresp_val, out_val;
   logic [31:0] imemresp_data, dmemresp_data, out_data;
`ifdef MEM_ALIGN_CHECK_EN
   logic        misalign_err;
`endif
   typedef struct packed {
      logic [31:0] due;
      logic [31:0] data;
   } exp_t;
   exp_t q[3][$];
   int cyc = 0, checks = 0, errors = 0;

   proc_mem_responder #(.WORDS(256), .LATENCY(LAT), .MMIO_ADDR(MMIO)) dut (
      .clk(clk), .rst(rst),
      .imemreq_val(imemreq_val), .imemreq_addr(imemreq_addr),
      .imemresp_val(imemresp_val), .imemresp_data(imemresp_data),
      .dmemreq_val(dmemreq_val), .dmemreq_type(dmemreq_type),
      .dmemreq_addr(dmemreq_addr), .dmemreq_wdata(dmemreq_wdata),
      .dmemresp_val(dmemresp_val), .dmemresp_data(dmemresp_data),
`ifdef MEM_ALIGN_CHECK_EN
      .misalign_err(misalign_err),
`endif
      .in_data(in_data), .out_val(out_val), .out_data(out_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_port(input int p, input string nm, input logic v, input logic [31:0] d);
      exp_t e;
      if (v) begin
         checks++;
         if (q[p].size() == 0) begin
            errors++;
            $display("FAIL %s unexpected val at cyc=%0d data=%h", nm, cyc, d);
         end else begin
            e = q[p].pop_front();
            if (e.due != 32'(cyc) || e.data != d) begin
               errors++;
               $display("FAIL %s got data=%h cyc=%0d expected data=%h cyc=%0d", nm, d, cyc, e.data, e.due);
            end
         end
      end else if (q[p].size() > 0 && q[p][0].due <= 32'(cyc)) begin
         checks++;
         errors++;
         $display("FAIL %s missing response at cyc=%0d expected data=%h", nm, cyc, q[p][0].data);
         void'(q[p].pop_front());
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         checks++;
         if (imemresp_val || dmemresp_val || out_val ||
             imemresp_data != 0 || dmemresp_data != 0 || out_data != 0) begin
            errors++;
            $display("FAIL reset_state got ival=%b dval=%b oval=%b idata=%h ddata=%h odata=%h expected all 0",
                     imemresp_val, dmemresp_val, out_val, imemresp_data, dmemresp_data, out_data);
         end
      end else begin
         check_port(0, "imem", imemresp_val, imemresp_data);
         check_port(1, "dmem", dmemresp_val, dmemresp_data);
         check_port(2, "mmio_out", out_val, out_data);
      end
   end

   task automatic req(input logic iv, input logic [31:0] ia, input logic [31:0] iexp,
                      input logic dv, input logic dt, input logic [31:0] da,
                      input logic [31:0] dw, input logic [31:0] dexp);
      @(posedge clk);
      #2;
      imemreq_val = iv; imemreq_addr = ia;
      dmemreq_val = dv; dmemreq_type = dt; dmemreq_addr = da; dmemreq_wdata = dw;
      if (iv) q[0].push_back('{due: 32'(cyc + LAT), data: iexp});
      if (dv) q[1].push_back('{due: 32'(cyc + LAT), data: dt ? 32'h0 : dexp});
      if (dv && dt && da == MMIO) q[2].push_back('{due: 32'(cyc + 1), data: dw});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) req(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      checks++;
      if (misalign_err !== 1'b0) begin
         errors++;
         $display("FAIL misalign_after_reset got %b expected 0", misalign_err);
      end
`endif
      req(0, 0, 0, 1, 1, 32'h0C, 32'hDEADBEEF, 0);
      req(0, 0, 0, 1, 1, 32'h20, 32'h11111111, 0);
      req(1, 32'h0C, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      idle(1);
      req(0, 0, 0, 1, 1, 32'h40, 32'h12345678, 0);
      req(0, 0, 0, 1, 0, 32'h40, 0, 32'h12345678);
      req(1, 32'h20, 32'h11111111, 1, 1, 32'h20, 32'hAAAA5555, 0);
      req(1, 32'h20, 32'hAAAA5555, 0, 0, 0, 0, 0);
      req(0, 0, 0, 1, 1, 32'h400, 32'h7, 0);
      req(0, 0, 0, 1, 0, 32'h000, 0, 32'h7);
      req(0, 0, 0, 1, 1, MMIO, 32'h55, 0);
      req(0, 0, 0, 1, 0, 32'h000, 0, 32'h7);
      req(0, 0, 0, 1, 1, MMIO, 32'h66, 0);
      req(0, 0, 0, 1, 1, MMIO, 32'h77, 0);
      in_data = 32'hCAFEF00D;
      req(1, MMIO, 32'hCAFEF00D, 1, 0, MMIO, 0, 32'hCAFEF00D);
      req(1, 32'h80C, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      idle(3);
      req(1, 32'h0C, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      req(0, 0, 0, 1, 0, 32'h40, 0, 32'h12345678);
      @(posedge clk);
      #2;
      rst = 1'b1;
      for (int p = 0; p < 3; p++) q[p].delete();
      imemreq_val = 1'b0; dmemreq_val = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      idle(3);
      req(0, 0, 0, 1, 0, 32'h40, 0, 32'h12345678);
      idle(4);
`ifdef MEM_ALIGN_CHECK_EN
      req(0, 0, 0, 1, 0, 32'h42, 0, 32'h12345678);
      idle(4);
      checks++;
      if (misalign_err !== 1'b1) begin
         errors++;
         $display("FAIL misalign_sticky got %b expected 1", misalign_err);
      end
`endif
      for (int p = 0; p < 3; p++) begin
         checks++;
         if (q[p].size() != 0) begin
            errors++;
            $display("FAIL leftover channel=%0d got %0d pending expected 0", p, q[p].size());
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
